// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction-fetch PC owner driving the ROM and the IF/ID register
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        misalign
);

    localparam logic        CHIP_ENA  = 1'b1;
    localparam logic        CHIP_DISA = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        rom_ce_q, rom_ce_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic        misalign_q, misalign_d;
    logic        branch_pend_q, branch_pend_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic [31:0] redirect_target;
    logic        redirect_sel;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_pc_d       = if_pc_q;
        if_inst_d     = if_inst_q;
        if_valid_d    = if_valid_q;
        misalign_d    = 1'b0;
        branch_pend_d = branch_pend_q;
        pend_target_d = pend_target_q;
        redirect_target = pc_q + 32'd4;
        redirect_sel    = 1'b0;

        if (branch_flag) begin
            redirect_target = branch_target;
            redirect_sel    = 1'b1;
        end else if (branch_pend_q) begin
            redirect_target = pend_target_q;
            redirect_sel    = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
                if (flush) begin
                    pc_d = new_pc;
                    if (new_pc[1:0] != 2'b00) begin
                        state_d    = S_ERR;
                        misalign_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    pc_d          = new_pc;
                    if_valid_d    = 1'b0;
                    if_inst_d     = ZERO_WORD;
                    if_pc_d       = 32'h0;
                    branch_pend_d = 1'b0;
                    if (new_pc[1:0] != 2'b00) begin
                        state_d    = S_ERR;
                        misalign_d = 1'b1;
                    end
                end else if (stall) begin
                    // Redirects seen while stalled are parked; the latest one wins.
                    if (branch_flag) begin
                        branch_pend_d = 1'b1;
                        pend_target_d = branch_target;
                    end
                end else begin
                    branch_pend_d = 1'b0;
                    if (redirect_sel && (redirect_target[1:0] != 2'b00)) begin
                        pc_d       = redirect_target;
                        misalign_d = 1'b1;
                        state_d    = S_ERR;
                        if_valid_d = 1'b0;
                    end else begin
                        if_inst_d  = rom_inst;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = redirect_target;
                    end
                end
            end
            S_ERR: begin
                if (flush) begin
                    pc_d          = new_pc;
                    if_valid_d    = 1'b0;
                    if_inst_d     = ZERO_WORD;
                    if_pc_d       = 32'h0;
                    branch_pend_d = 1'b0;
                    if (new_pc[1:0] == 2'b00) begin
                        state_d = S_RUN;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rom_ce_d = (state_d == S_RUN) ? CHIP_ENA : CHIP_DISA;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            rom_ce_q      <= CHIP_DISA;
            if_pc_q       <= 32'h0;
            if_inst_q     <= ZERO_WORD;
            if_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
            branch_pend_q <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rom_ce_q      <= rom_ce_d;
            if_pc_q       <= if_pc_d;
            if_inst_q     <= if_inst_d;
            if_valid_q    <= if_valid_d;
            misalign_q    <= misalign_d;
            branch_pend_q <= branch_pend_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign rom_ce   = rom_ce_q;
    assign rom_addr = pc_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] new_pc;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        misalign;

    int tests_run;
    int tests_failed;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .new_pc        (new_pc),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid),
        .misalign      (misalign)
    );

    // Word i at byte address 4*i holds 0x1000_0000 + i.
    assign rom_inst = 32'h1000_0000 + {2'b00, rom_addr[31:2]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;
        flush = 1'b0; new_pc = 32'h0;
        tick(); tick();
        tests_run++; if (rom_ce !== 1'b0) begin tests_failed++; $display("FAIL reset_rom_ce got %0h exp 0", rom_ce); end
        tests_run++; if (rom_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_rom_addr got %h exp 00000000", rom_addr); end
        tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_if_valid got %0h exp 0", if_valid); end
        tests_run++; if (if_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_if_pc got %h exp 00000000", if_pc); end
        tests_run++; if (if_inst !== 32'h0) begin tests_failed++; $display("FAIL reset_if_inst got %h exp 00000000", if_inst); end
        tests_run++; if (misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign got %0h exp 0", misalign); end
    endtask

    task automatic test_sequential();
        rst = 1'b1;
        tests_run++; if (rom_ce !== 1'b0) begin tests_failed++; $display("FAIL idle_rom_ce got %0h exp 0", rom_ce); end
        tick();
        tests_run++; if (rom_ce !== 1'b1) begin tests_failed++; $display("FAIL run_rom_ce got %0h exp 1", rom_ce); end
        tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_no_capture got %0h exp 0", if_valid); end
        tick();
        tests_run++; if (if_pc !== 32'h0 || if_inst !== 32'h1000_0000 || if_valid !== 1'b1) begin
            tests_failed++; $display("FAIL seq_word0 got pc=%h inst=%h v=%0h exp 00000000 10000000 1", if_pc, if_inst, if_valid); end
        tick();
        tests_run++; if (if_pc !== 32'h4 || if_inst !== 32'h1000_0001 || rom_addr !== 32'h8) begin
            tests_failed++; $display("FAIL seq_word1 got pc=%h inst=%h addr=%h exp 00000004 10000001 00000008", if_pc, if_inst, rom_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (rom_addr !== 32'h8 || if_pc !== 32'h4 || if_inst !== 32'h1000_0001 || if_valid !== 1'b1) begin
                tests_failed++; $display("FAIL stall_hold%0d got addr=%h pc=%h inst=%h exp 00000008 00000004 10000001", i, rom_addr, if_pc, if_inst); end
        end
        stall = 1'b0;
        tick();
        tests_run++; if (if_pc !== 32'h8 || if_inst !== 32'h1000_0002 || rom_addr !== 32'hC) begin
            tests_failed++; $display("FAIL stall_release got pc=%h inst=%h addr=%h exp 00000008 10000002 0000000c", if_pc, if_inst, rom_addr); end
    endtask

    task automatic test_branch();
        tick();
        tests_run++; if (if_pc !== 32'hC) begin tests_failed++; $display("FAIL br_pre got %h exp 0000000c", if_pc); end
        branch_flag = 1'b1; branch_target = 32'h40;
        tick();
        branch_flag = 1'b0;
        tests_run++; if (if_pc !== 32'h10 || if_inst !== 32'h1000_0004 || rom_addr !== 32'h40) begin
            tests_failed++; $display("FAIL br_delay_slot got pc=%h inst=%h addr=%h exp 00000010 10000004 00000040", if_pc, if_inst, rom_addr); end
        tick();
        tests_run++; if (if_pc !== 32'h40 || if_inst !== 32'h1000_0010) begin
            tests_failed++; $display("FAIL br_target got pc=%h inst=%h exp 00000040 10000010", if_pc, if_inst); end
        tick();
        tests_run++; if (if_pc !== 32'h44 || if_inst !== 32'h1000_0011) begin
            tests_failed++; $display("FAIL br_after got pc=%h inst=%h exp 00000044 10000011", if_pc, if_inst); end
    endtask

    task automatic test_branch_during_stall();
        branch_flag = 1'b1; branch_target = 32'h20;
        tick();
        stall = 1'b1; branch_target = 32'h80;
        tick();
        branch_flag = 1'b0;
        tests_run++; if (rom_addr !== 32'h20 || if_pc !== 32'h48) begin
            tests_failed++; $display("FAIL bs_hold got addr=%h pc=%h exp 00000020 00000048", rom_addr, if_pc); end
        tick();
        stall = 1'b0;
        tick();
        tests_run++; if (if_pc !== 32'h20 || rom_addr !== 32'h80) begin
            tests_failed++; $display("FAIL bs_release got pc=%h addr=%h exp 00000020 00000080", if_pc, rom_addr); end
        tick();
        tests_run++; if (if_pc !== 32'h80 || if_inst !== 32'h1000_0020) begin
            tests_failed++; $display("FAIL bs_target got pc=%h inst=%h exp 00000080 10000020", if_pc, if_inst); end
    endtask

    task automatic test_flush();
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
        tick();
        branch_flag = 1'b0; flush = 1'b1; new_pc = 32'h180;
        tick();
        flush = 1'b0; stall = 1'b0;
        tests_run++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc !== 32'h0 || rom_addr !== 32'h180) begin
            tests_failed++; $display("FAIL flush_bubble got v=%0h inst=%h pc=%h addr=%h exp 0 0 0 00000180", if_valid, if_inst, if_pc, rom_addr); end
        tick();
        tests_run++; if (if_pc !== 32'h180 || if_inst !== 32'h1000_0060 || if_valid !== 1'b1 || rom_addr !== 32'h184) begin
            tests_failed++; $display("FAIL flush_target got pc=%h inst=%h v=%0h addr=%h exp 00000180 10000060 1 00000184", if_pc, if_inst, if_valid, rom_addr); end
    endtask

    task automatic test_misalign();
        branch_flag = 1'b1; branch_target = 32'h42;
        tick();
        branch_flag = 1'b0;
        tests_run++; if (misalign !== 1'b1 || rom_ce !== 1'b0 || if_valid !== 1'b0 || rom_addr !== 32'h42) begin
            tests_failed++; $display("FAIL mis_enter got mis=%0h ce=%0h v=%0h addr=%h exp 1 0 0 00000042", misalign, rom_ce, if_valid, rom_addr); end
        for (int i = 0; i < 5; i++) begin
            stall = i[0]; branch_flag = ~i[0]; branch_target = 32'h300;
            tick();
            tests_run++; if (misalign !== 1'b0 || rom_ce !== 1'b0 || if_valid !== 1'b0 || rom_addr !== 32'h42) begin
                tests_failed++; $display("FAIL mis_hold%0d got mis=%0h ce=%0h v=%0h addr=%h exp 0 0 0 00000042", i, misalign, rom_ce, if_valid, rom_addr); end
        end
        stall = 1'b0; branch_flag = 1'b0; flush = 1'b1; new_pc = 32'h100;
        tick();
        flush = 1'b0;
        tests_run++; if (rom_ce !== 1'b1 || if_valid !== 1'b0 || rom_addr !== 32'h100) begin
            tests_failed++; $display("FAIL mis_flush got ce=%0h v=%0h addr=%h exp 1 0 00000100", rom_ce, if_valid, rom_addr); end
        tick();
        tests_run++; if (if_pc !== 32'h100 || if_inst !== 32'h1000_0040 || if_valid !== 1'b1) begin
            tests_failed++; $display("FAIL mis_resume got pc=%h inst=%h v=%0h exp 00000100 10000040 1", if_pc, if_inst, if_valid); end
    endtask

    task automatic test_wrap();
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        tick();
        tests_run++; if (if_pc !== 32'hFFFF_FFFC || if_inst !== 32'h4FFF_FFFF || rom_addr !== 32'h0) begin
            tests_failed++; $display("FAIL wrap got pc=%h inst=%h addr=%h exp fffffffc 4fffffff 00000000", if_pc, if_inst, rom_addr); end
    endtask

    task automatic test_reset_midop();
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h400;
        tick();
        branch_flag = 1'b0;
        #3 rst = 1'b0;
        #1;
        tests_run++; if (rom_ce !== 1'b0 || if_valid !== 1'b0 || rom_addr !== 32'h0 || if_pc !== 32'h0) begin
            tests_failed++; $display("FAIL async_reset got ce=%0h v=%0h addr=%h pc=%h exp 0 0 0 0", rom_ce, if_valid, rom_addr, if_pc); end
        tick();
        rst = 1'b1; stall = 1'b0;
        tick();
        tick();
        tests_run++; if (if_pc !== 32'h0 || if_inst !== 32'h1000_0000 || rom_addr !== 32'h4) begin
            tests_failed++; $display("FAIL reset_pend_lost got pc=%h inst=%h addr=%h exp 0 10000000 00000004", if_pc, if_inst, rom_addr); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_branch_during_stall();
        test_flush();
        test_misalign();
        test_wrap();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
